// File: rtl/muxnto1_rr_if.sv
// rtl/muxnto1_rr_if.sv - stream bundle between N producers, the mux and one consumer
interface muxnto1_rr_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4
);
  localparam int SW = $clog2(N);

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [SW-1:0]      out_chan;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_chan
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_chan
  );
endinterface

// File: rtl/muxnto1_rr.sv
// rtl/muxnto1_rr.sv - N-to-1 registered mux, select-driven or round-robin, valid/ready on all sides
// Optional transfer counter output grant_cnt when MUXNTO1_CNT_EN is defined.
module muxnto1_rr #(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 mode,
  input  logic [$clog2(N)-1:0] sel,
  muxnto1_rr_if.slave          bus
`ifdef MUXNTO1_CNT_EN
  ,
  output logic [15:0]          grant_cnt
`endif
);
  localparam int SW = $clog2(N);

  logic [SW-1:0] ptr;
  logic [SW-1:0] g;
  logic [SW-1:0] g_lo;
  logic [SW-1:0] g_hi;
  logic          found_lo;
  logic          found_hi;
  logic          grant;
  logic          load;

  assign load = en & (~bus.out_valid | bus.out_ready);

  // Round-robin search split in two: lowest valid at or above ptr, else lowest valid overall.
  always_comb begin
    g_lo     = '0;
    g_hi     = '0;
    found_lo = 1'b0;
    found_hi = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.in_valid[i]) begin
        g_lo     = SW'(i);
        found_lo = 1'b1;
        if (i >= int'(ptr)) begin
          g_hi     = SW'(i);
          found_hi = 1'b1;
        end
      end
    end
  end

  always_comb begin
    g     = '0;
    grant = 1'b0;
    if (mode) begin
      grant = found_lo;
      g     = found_hi ? g_hi : g_lo;
    end else if ((32'(sel) < N) && bus.in_valid[sel]) begin
      grant = 1'b1;
      g     = sel;
    end
  end

  always_comb begin
    bus.in_ready = '0;
    if (load && grant && !rst) begin
      bus.in_ready[g] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
      bus.out_chan  <= '0;
      ptr           <= '0;
    end else if (load) begin
      if (grant) begin
        bus.out_data  <= bus.in_data[g*WIDTH +: WIDTH];
        bus.out_chan  <= g;
        bus.out_valid <= 1'b1;
        // Wrap at N rather than 2^SW so non-power-of-two channel counts stay fair.
        if (mode) begin
          ptr <= (32'(g) == N - 1) ? '0 : g + 1'b1;
        end
      end else begin
        bus.out_valid <= 1'b0;
      end
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

`ifdef MUXNTO1_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt <= '0;
    end else if (bus.out_valid && bus.out_ready && (grant_cnt != 16'hFFFF)) begin
      grant_cnt <= grant_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_muxnto1_rr.sv
// tb/tb_muxnto1_rr.sv - scoreboard bench for muxnto1_rr against a queue-based reference model
module tb_muxnto1_rr;
  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int SW    = 2;

  typedef logic [WIDTH+SW-1:0] word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en;
  logic mode;
  logic [SW-1:0] sel;

  always #5 clk = ~clk;

  muxnto1_rr_if #(.WIDTH(WIDTH), .N(N)) bus ();
  muxnto1_rr_if #(.WIDTH(WIDTH), .N(3)) bus3 ();

`ifdef MUXNTO1_CNT_EN
  logic [15:0] grant_cnt;
  logic [15:0] grant_cnt3;
`endif

  muxnto1_rr #(.WIDTH(WIDTH), .N(N)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .bus(bus)
`ifdef MUXNTO1_CNT_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  muxnto1_rr #(.WIDTH(WIDTH), .N(3)) dut3 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .bus(bus3)
`ifdef MUXNTO1_CNT_EN
    , .grant_cnt(grant_cnt3)
`endif
  );

  int    vecs = 0;
  int    errs = 0;
  word_t expq[$];
  logic  m_valid = 1'b0;
  int    m_ptr = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every accepted output word must be the oldest one the model predicted.
  always @(negedge clk) begin
    #1;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (expq.size() == 0) begin
        check("unexpected_word", {22'd0, bus.out_data, bus.out_chan}, 32'hFFFF_FFFF);
      end else begin
        word_t w;
        w = expq.pop_front();
        check("out_word", {22'd0, bus.out_data, bus.out_chan}, {22'd0, w});
      end
    end
  end

  // One clock of stimulus plus the reference model's view of that cycle.
  task automatic cycle(input logic e, input logic m, input logic [SW-1:0] s,
                       input logic [N-1:0] v, input logic [N*WIDTH-1:0] d, input logic ordy);
    int g;
    logic ld;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    en = e; mode = m; sel = s;
    bus.in_valid = v; bus.in_data = d; bus.out_ready = ordy;
    #1;
    ld = e && (!m_valid || ordy);
    g = -1;
    if (!m) begin
      if (int'(s) < N && v[s]) g = int'(s);
    end else begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    exp_rdy = '0;
    if (ld && g >= 0) exp_rdy[g] = 1'b1;
    check("in_ready", {28'd0, bus.in_ready}, {28'd0, exp_rdy});
    check("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
    if (ld) begin
      if (g >= 0) begin
        expq.push_back({d[g*WIDTH +: WIDTH], SW'(g)});
        m_valid = 1'b1;
        if (m) m_ptr = (g + 1) % N;
      end else begin
        m_valid = 1'b0;
      end
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_data", {24'd0, bus.out_data}, 32'd0);
    check("rst_out_chan", {30'd0, bus.out_chan}, 32'd0);
    check("rst_in_ready", {28'd0, bus.in_ready}, 32'd0);
    bus.in_valid = '0;
    expq.delete();
    m_valid = 1'b0;
    m_ptr = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    en = 1'b1; mode = 1'b0; sel = '0;
    bus.in_valid = '1; bus.in_data = 32'h1234_5678; bus.out_ready = 1'b1;
    bus3.in_valid = '0; bus3.in_data = '0; bus3.out_ready = 1'b1;
    #12;
    check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset_out_data", {24'd0, bus.out_data}, 32'd0);
    check("reset_out_chan", {30'd0, bus.out_chan}, 32'd0);
    check("reset_in_ready", {28'd0, bus.in_ready}, 32'd0);
    bus.in_valid = '0;
    @(negedge clk);
    rst = 1'b0;

    // Select-driven: channel 2 carries A5.
    cycle(1'b1, 1'b0, 2'd2, 4'b1111, 32'h11A5_2233, 1'b1);
    cycle(1'b1, 1'b0, 2'd0, 4'b0000, 32'h0, 1'b1);

    // Round-robin over four always-valid channels.
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 2'd0, 4'b1111, $urandom, 1'b1);
    cycle(1'b1, 1'b0, 2'd0, 4'b0000, 32'h0, 1'b1);

    // Backpressure: 3C held for five cycles, then replaced without a bubble.
    cycle(1'b1, 1'b0, 2'd1, 4'b0010, 32'h0000_3C00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 2'd1, 4'b1111, $urandom, 1'b0);
      check("bp_out_data", {24'd0, bus.out_data}, 32'h3C);
    end
    cycle(1'b1, 1'b0, 2'd3, 4'b1000, 32'h5A00_0000, 1'b1);
    cycle(1'b1, 1'b0, 2'd0, 4'b0000, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 2'd0, 4'b0000, 32'h0, 1'b1);

    // Enable low drains a pending word without capturing.
    cycle(1'b1, 1'b0, 2'd1, 4'b0010, $urandom, 1'b1);
    cycle(1'b0, 1'b0, 2'd1, 4'b1111, $urandom, 1'b1);
    cycle(1'b0, 1'b1, 2'd1, 4'b1111, $urandom, 1'b1);

    // Reset while a word is held.
    cycle(1'b1, 1'b1, 2'd0, 4'b0100, $urandom, 1'b0);
    do_reset();
    cycle(1'b1, 1'b1, 2'd0, 4'b1111, $urandom, 1'b1);
    cycle(1'b1, 1'b0, 2'd0, 4'b0000, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 2'd0, 4'b0000, 32'h0, 1'b1);

    // Three-channel instance: pointer wraps at N, out-of-range select never grants.
    en = 1'b1; mode = 1'b1; sel = 2'd0;
    @(negedge clk);
    bus3.in_valid = 3'b100; bus3.in_data = 24'h77_0000;
    #1;
    check("n3_rdy_ch2", {29'd0, bus3.in_ready}, 32'b100);
    @(negedge clk);
    bus3.in_valid = 3'b101; bus3.in_data = 24'h66_0011;
    #1;
    check("n3_rdy_wrap", {29'd0, bus3.in_ready}, 32'b001);
    check("n3_chan_2", {30'd0, bus3.out_chan}, 32'd2);
    check("n3_data_77", {24'd0, bus3.out_data}, 32'h77);
    @(negedge clk);
    #1;
    check("n3_rdy_next", {29'd0, bus3.in_ready}, 32'b100);
    check("n3_chan_0", {30'd0, bus3.out_chan}, 32'd0);
    @(negedge clk);
    mode = 1'b0; sel = 2'd3; bus3.in_valid = 3'b111;
    #1;
    check("n3_sel_oob", {29'd0, bus3.in_ready}, 32'd0);
    sel = 2'd1;
    #1;
    check("n3_sel_1", {29'd0, bus3.in_ready}, 32'b010);
    bus3.in_valid = '0;

    // Randomised traffic.
    for (int i = 0; i < 500; i++) begin
      cycle($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            4'($urandom), $urandom, $urandom_range(0, 3) != 0);
    end

`ifdef MUXNTO1_CNT_EN
    do_reset();
    for (int i = 0; i < 11; i++) cycle(1'b1, 1'b1, 2'd0, 4'b1111, $urandom, 1'b1);
    @(posedge clk);
    #1;
    check("grant_cnt_10", {16'd0, grant_cnt}, 32'd10);
    force dut.grant_cnt = 16'hFFFD;
    #1;
    release dut.grant_cnt;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 2'd0, 4'b1111, $urandom, 1'b1);
    @(posedge clk);
    #1;
    check("grant_cnt_sat", {16'd0, grant_cnt}, 32'hFFFF);
`endif

    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 2'd0, 4'b0000, 32'h0, 1'b1);
    check("queue_drained", expq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/muxnto1_rr.md
# muxnto1_rr

Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready handshaking on every input and on the output. Replaces the fixed 4-to-1 combinational multiplexer where channel count, data width, flow control or fair sharing are needed. Operates either as an externally selected multiplexer or as a round-robin arbiter over the valid inputs, feeding a one-entry output register. It sits between N producer streams and a single consumer.

## Interface
- `WIDTH`, 8: data bits per channel.
- `N`, 4: number of input channels, ≥2, need not be a power of two.
- `SW`, `$clog2(N)`: select/channel index width. This is a localparam, not overridable.
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  enable; low blocks new captures.
- `mode`  in  1  0 = select-driven by `sel`, 1 = round-robin.
- `sel`  in  SW  channel index used in mode 0.
- `in_data`  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid`  in  N  per-channel valid.
- `in_ready`  out  N  per-channel ready, combinational, one-hot or zero.
- `out_data`  out  WIDTH  registered data.
- `out_valid`  out  1  registered valid.
- `out_ready`  in  1  consumer ready.
- `out_chan`  out  SW  index of the channel that sourced `out_data`.

## Operation
- `load = en & (~out_valid | out_ready)`: the register is empty or is draining this cycle.
- Grant `g` in mode 0:
  - `g = sel` if `sel < N` and `in_valid[sel]`.
  - Otherwise no grant. Out-of-range `sel` never grants.
- Grant `g` in mode 1:
  - `g` is the first i with `in_valid[i]` set, searching `ptr, ptr+1, …, N-1, 0, …, ptr-1`.
  - No grant if `in_valid` is all zero.
- `in_ready[g] = load & grant`. Every other bit is 0. All bits are 0 while `rst` is high.
- Clock edge with `load` and a grant:
  - `out_data <= in_data[g]`, `out_chan <= g`, `out_valid <= 1`.
  - In mode 1 only, `ptr <= (g == N-1) ? 0 : g+1`. The pointer wraps at N, not at 2^SW.
- Clock edge with `load` and no grant: `out_valid <= 0`. `out_data` and `out_chan` hold.
- Clock edge with `en` low:
  - No capture.
  - If `out_valid & out_ready`, then `out_valid <= 0`, so a pending word still drains.
  - Otherwise all state holds.
- Mode 0 grants leave `ptr` unchanged. Changing `mode` or `sel` takes effect on the next grant decision. A word already in the register is unaffected.

## Timing
- Reset values: `out_data = 0`, `out_valid = 0`, `out_chan = 0`, `ptr = 0`.
- Latency: 1 cycle from the input handshake (`in_valid[g] & in_ready[g]`) to `out_valid`.
- Throughput: 1 word per cycle when `out_ready` is held high. There are no bubbles.
- Simultaneous output drain and new grant: the register is overwritten in the same edge. No word is lost or duplicated.
- Backpressure: with `out_valid = 1` and `out_ready = 0`, `in_ready` is all zero and `out_data` is stable.
- `in_ready` depends combinationally on `in_valid`, `sel`, `mode`, `en`, `out_ready` and state. Producers must not make `in_valid` depend on `in_ready`.
- Reset asserted mid-transfer discards the registered word immediately, asynchronously. The first grant after deassertion searches from channel 0.

## Configuration
- `MUXNTO1_CNT_EN` defined:
  - Adds output `grant_cnt  out  16`, the count of accepted output transfers (`out_valid & out_ready`).
  - The counter saturates at 16'hFFFF and resets to 0.
- `MUXNTO1_CNT_EN` undefined: the port and counter do not exist. All other behaviour is identical.

## Test plan
- Mode 0, N=4, WIDTH=8:
  - Stimulus: `sel = 2`, `in_valid = 4'b1111`, channel 2 data = 8'hA5, `out_ready = 1`.
  - Required response: `in_ready = 4'b0100`; next cycle `out_data = 8'hA5`, `out_chan = 2`, `out_valid = 1`.
- Mode 1, all four valid, `out_ready = 1`, 8 cycles:
  - Required response: `out_chan` sequence is 0,1,2,3,0,1,2,3.
- Mode 1, N=3, only channel 2 valid, then channels 0 and 2:
  - Required response: after channel 2 is granted, `ptr` wraps to 0; next grant is channel 0, then channel 2.
- Backpressure: word 8'h3C registered, `out_ready = 0` for 5 cycles.
  - Required response: `out_data` stays 8'h3C, `out_valid` stays 1, `in_ready = 0`.
  - Then `out_ready = 1` with a new valid input: the register is replaced in one edge with no bubble.
- `en` low, and reset mid-stream:
  - `en = 0` while `out_valid = 1` and `out_ready = 1`: `out_valid` goes to 0 next edge, with no capture.
  - Assert `rst` while `out_valid = 1`: `out_valid`, `out_data` and `out_chan` go to 0 immediately.
- `MUXNTO1_CNT_EN`:
  - 10 accepted transfers: `grant_cnt = 10`.
  - Preload near 16'hFFFF by forcing, then run 3 more transfers: `grant_cnt` holds at 16'hFFFF.
